// File: rtl/wdt_pkg.sv
// Shared defaults and fault-bit layout for the windowed watchdog.
package wdt_pkg;

  localparam int unsigned DEF_CNT_W = 16;
  localparam int unsigned DEF_NCH   = 4;

  localparam int unsigned FLT_OVR   = 0;
  localparam int unsigned FLT_EARLY = 1;
  localparam int unsigned NFLT      = 2;

endpackage

// File: rtl/wdt_channel.sv
// One watchdog channel: window counter, service/timeout priority logic and
// the two sticky fault flags.
module wdt_channel
  import wdt_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             srvc,
  input  logic             clr,
  input  logic [CNT_W-1:0] wopen_eff,
  input  logic [CNT_W-1:0] wclose,
  output logic             fwovr,
  output logic             fwearly,
  output logic             winopen
);

  logic [CNT_W-1:0] q_q, q_d;
  logic [NFLT-1:0]  flt_q, flt_d, flt_set;

  always_comb begin
    q_d     = q_q;
    flt_set = '0;
    if (!en) begin
      q_d = '0;
    end else if (srvc) begin
      q_d                = '0;
      flt_set[FLT_EARLY] = (q_q < wopen_eff);
    end else if (q_q == wclose) begin
      q_d              = '0;
      flt_set[FLT_OVR] = 1'b1;
    end else begin
      q_d = q_q + 1'b1;
    end
    // A fault raised on the same edge as a clear wins.
    flt_d = (flt_q & ~{NFLT{clr}}) | flt_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q   <= '0;
      flt_q <= '0;
    end else begin
      q_q   <= q_d;
      flt_q <= flt_d;
    end
  end

  assign fwovr   = flt_q[FLT_OVR];
  assign fwearly = flt_q[FLT_EARLY];
  // Gated by reset so the window reads closed while the block is held in reset.
  assign winopen = rst_n & en & (q_q >= wopen_eff);

endmodule

// File: rtl/window_watchdog.sv
// Multi-channel windowed watchdog: per-channel window unpacking, effective
// open-bound selection and a registered combined interrupt.
module window_watchdog
  import wdt_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W,
  parameter int unsigned NCH   = DEF_NCH
) (
  input  logic                 CLK,
  input  logic                 RSTN,
  input  logic [NCH-1:0]       EN,
  input  logic [NCH-1:0]       SRVC,
  input  logic [NCH-1:0]       CLR,
  input  logic [NCH*CNT_W-1:0] WOPEN,
  input  logic [NCH*CNT_W-1:0] WCLOSE,
  output logic [NCH-1:0]       FWOVR,
  output logic [NCH-1:0]       FWEARLY,
  output logic [NCH-1:0]       WINOPEN,
  output logic                 IRQ
);

  logic irq_q;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [CNT_W-1:0] wopen, wclose, wopen_eff;

    assign wopen  = WOPEN[i*CNT_W +: CNT_W];
    assign wclose = WCLOSE[i*CNT_W +: CNT_W];
    // An inverted window is treated as open for the whole period.
    assign wopen_eff = (wopen > wclose) ? '0 : wopen;

    wdt_channel #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk      (CLK),
      .rst_n    (RSTN),
      .en       (EN[i]),
      .srvc     (SRVC[i]),
      .clr      (CLR[i]),
      .wopen_eff(wopen_eff),
      .wclose   (wclose),
      .fwovr    (FWOVR[i]),
      .fwearly  (FWEARLY[i]),
      .winopen  (WINOPEN[i])
    );
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= |{FWOVR, FWEARLY};
    end
  end

  assign IRQ = irq_q;

endmodule
